// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes and select encodings for the MIPS main control
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory ready handshake
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mem_wait_counter.sv
// rtl/mips_mem_wait_counter.sv - memory wait cycle counter with sticky timeout flag
module mips_mem_wait_counter #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic wait_i,
    output logic mem_timeout_o
);

    localparam logic [3:0] MAX_CNT = 4'(MEM_WAIT_MAX);

    logic [3:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (wait_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Saturates at the limit; the flag only clears on reset
        if (cnt_d == MAX_CNT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

endmodule

// File: rtl/mips_main_control.sv
// rtl/mips_main_control.sv - multicycle MIPS main control FSM; MIPS_MAIN_CONTROL_BNE_EN adds bne
module mips_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_src    = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target while decoding
                alu_src_b = SRCB_IMM_SL2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
`ifdef MIPS_MAIN_CONTROL_BNE_EN
                        state_d = S_BRANCH;
`else
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
`endif
                    end
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                pc_src    = PCSRC_ALUOUT;
`ifdef MIPS_MAIN_CONTROL_BNE_EN
                branch_ne = opcode[0];
`endif
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic wait_cycle;
    logic state_change;

    assign wait_cycle   = is_mem_state(state_q) && !mem_ready;
    assign state_change = (state_d != state_q);

    mips_mem_wait_counter #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_counter (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (state_change),
        .wait_i       (wait_cycle),
        .mem_timeout_o(mem_timeout)
    );

endmodule
